// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : cpu_pkg
//  Description : Shared encodings for the 16-bit MSP430-style core front end.
//                Holds the sequencer state codes, the jump opcode, the eight
//                jump condition codes and the status-flag bit positions
//                inside the 4-bit {V,N,Z,C} flag vector.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // ------------------------------------------------------------------------
    // Sequencer state encoding (also exported on the fsm_state debug port)
    // ------------------------------------------------------------------------
    localparam logic [2:0] S_RESET  = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_ISSUE  = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;

    // ------------------------------------------------------------------------
    // Jump format: instr[15:13] = JMP_OPC, instr[12:10] = condition,
    // instr[9:0] = signed word offset relative to the already-advanced PC.
    // ------------------------------------------------------------------------
    localparam logic [2:0] JMP_OPC  = 3'b001;

    localparam logic [2:0] COND_JNE = 3'b000;   // !Z
    localparam logic [2:0] COND_JEQ = 3'b001;   //  Z
    localparam logic [2:0] COND_JNC = 3'b010;   // !C
    localparam logic [2:0] COND_JC  = 3'b011;   //  C
    localparam logic [2:0] COND_JN  = 3'b100;   //  N
    localparam logic [2:0] COND_JGE = 3'b101;   // !(N ^ V)
    localparam logic [2:0] COND_JL  = 3'b110;   //  N ^ V
    localparam logic [2:0] COND_JMP = 3'b111;   // always

    // ------------------------------------------------------------------------
    // Bit positions inside flags[3:0] = {V,N,Z,C}
    // ------------------------------------------------------------------------
    localparam int FLG_C = 0;
    localparam int FLG_Z = 1;
    localparam int FLG_N = 2;
    localparam int FLG_V = 3;

    // True when the instruction word belongs to the jump group.
    function automatic logic is_jump(input logic [15:0] word);
        return (word[15:13] == JMP_OPC);
    endfunction

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/jump_cond_eval.sv
`default_nettype none
// ============================================================================
//  Module      : jump_cond_eval
//  Description : Purely combinational jump-condition evaluator. Decides
//                whether a jump with condition code `cond` is taken given
//                the current status flags.
//  Ports       :
//      cond   in  3   jump condition field (instr[12:10])
//      flags  in  4   status flags {V,N,Z,C}
//      take   out 1   1 = jump taken
//  Revision    : 1.0 - initial release
// ============================================================================
module jump_cond_eval
    import cpu_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [3:0] flags,
    output logic       take
);

    logic flag_c;
    logic flag_z;
    logic flag_n;
    logic flag_v;

    assign flag_c = flags[FLG_C];
    assign flag_z = flags[FLG_Z];
    assign flag_n = flags[FLG_N];
    assign flag_v = flags[FLG_V];

    always_comb begin
        take = 1'b0;
        case (cond)
            COND_JNE: take = ~flag_z;
            COND_JEQ: take =  flag_z;
            COND_JNC: take = ~flag_c;
            COND_JC:  take =  flag_c;
            COND_JN:  take =  flag_n;
            // Signed comparisons: N^V is the true sign of the subtraction
            // result once overflow is taken into account.
            COND_JGE: take = ~(flag_n ^ flag_v);
            COND_JL:  take =  (flag_n ^ flag_v);
            COND_JMP: take = 1'b1;
            default:  take = 1'b0;
        endcase
    end

endmodule : jump_cond_eval
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : Program-counter sequencer for the 16-bit MSP430-style core.
//                Owns the PC, runs the instruction-memory fetch handshake,
//                resolves every jump locally from the status flags and hands
//                all other instructions to the control unit over valid/ready,
//                then waits for retire. Strictly one instruction in flight.
//  Ports       :
//      clk           in   1     system clock, rising edge
//      rst_n         in   1     asynchronous active-low reset
//      imem_req      out  1     fetch request, held until imem_ack
//      imem_addr     out  PC_W  fetch address (always the PC)
//      imem_ack      in   1     fetch data valid this cycle
//      imem_rdata    in   16    fetched instruction word
//      instr_valid   out  1     instruction valid to the control unit
//      instr         out  16    issued instruction, stable while valid
//      instr_ready   in   1     control unit accepts instr
//      retire        in   1     control unit finished; flags are current
//      redirect_en   in   1     with retire: load redirect_pc into the PC
//      redirect_pc   in   PC_W  redirect target (bit 0 is forced to 0)
//      flags         in   4     status flags {V,N,Z,C}
//      pc            out  PC_W  current PC (address of the next fetch)
//      branch_taken  out  1     one-cycle pulse when a jump is taken
//      fsm_state     out  3     current sequencer state, debug only
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(16'hC000),
    parameter int              OFF_W    = 10
) (
    input  logic            clk,
    input  logic            rst_n,

    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [15:0]     imem_rdata,

    output logic            instr_valid,
    output logic [15:0]     instr,
    input  logic            instr_ready,
    input  logic            retire,
    input  logic            redirect_en,
    input  logic [PC_W-1:0] redirect_pc,

    input  logic [3:0]      flags,

    output logic [PC_W-1:0] pc,
    output logic            branch_taken,
    output logic [2:0]      fsm_state
);

    // PC values are halfword aligned; bit 0 is cleared wherever a PC is loaded.
    localparam logic [PC_W-1:0] PC_ALIGN_MASK = ~PC_W'(1);

    // ------------------------------------------------------------------------
    // Internal state
    // ------------------------------------------------------------------------
    logic [2:0]      state;
    logic [2:0]      state_next;
    logic [15:0]     ir;            // word captured on the fetch handshake

    logic            ir_is_jump;
    logic            cond_take;
    logic            jump_take;
    logic [PC_W-1:0] pc_plus2;
    logic [PC_W-1:0] jump_disp;
    logic [PC_W-1:0] jump_target;

    // ------------------------------------------------------------------------
    // Jump resolution
    // ------------------------------------------------------------------------
    jump_cond_eval u_jump_cond_eval (
        .cond  (ir[12:10]),
        .flags (flags),
        .take  (cond_take)
    );

    assign ir_is_jump = is_jump(ir);
    assign jump_take  = ir_is_jump & cond_take;

    // Word offset -> byte displacement: sign-extend and shift left by one.
    // The PC has already been advanced past the jump word when this is used,
    // so the target is relative to the following instruction.
    assign jump_disp   = {{(PC_W-OFF_W-1){ir[OFF_W-1]}}, ir[OFF_W-1:0], 1'b0};
    assign jump_target = pc + jump_disp;
    assign pc_plus2    = pc + PC_W'(2);

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_RESET;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            S_RESET:  state_next = S_FETCH;
            S_FETCH:  if (imem_ack)    state_next = S_DECODE;
            // Jumps are fully resolved here and never reach the control unit.
            S_DECODE: state_next = ir_is_jump ? S_FETCH : S_ISSUE;
            S_ISSUE:  if (instr_ready) state_next = S_WAIT;
            // retire is only honoured here, so a retire coinciding with the
            // hand-off cycle in S_ISSUE is deliberately dropped.
            S_WAIT:   if (retire)      state_next = S_FETCH;
            default:  state_next = S_RESET;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs (decoded from the registered state so they drop the
    // instant rst_n is asserted)
    // ------------------------------------------------------------------------
    always_comb begin
        imem_req     = 1'b0;
        instr_valid  = 1'b0;
        branch_taken = 1'b0;
        case (state)
            S_FETCH:  imem_req     = 1'b1;
            S_DECODE: branch_taken = jump_take;
            S_ISSUE:  instr_valid  = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: PC, instruction register, issued instruction
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= RESET_PC & PC_ALIGN_MASK;
            ir    <= '0;
            instr <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_ack) begin
                        ir <= imem_rdata;
                        pc <= pc_plus2;
                    end
                end
                S_DECODE: begin
                    if (ir_is_jump) begin
                        if (jump_take) begin
                            pc <= jump_target;
                        end
                    end else begin
                        instr <= ir;
                    end
                end
                S_WAIT: begin
                    if (retire && redirect_en) begin
                        pc <= redirect_pc & PC_ALIGN_MASK;
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem_addr = pc;
    assign fsm_state = state;

endmodule : pc_sequencer
`default_nettype wire
